regfile_multiport: RTL and testbench

//  Parametrised multi-port register file for the core: NR registered read ports, NW write ports.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_clear_fsm.sv | 69 ++++++
 rtl/regfile_multiport.sv | 120 ++++++++++++
 tb/tb_regfile_multiport.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default parameters for the multi-port register file.
package regfile_pkg;

    // The sweep FSM has two states: zeroing the array, or normal operation.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    // Default configuration used by the core.
    localparam int RF_WIDTH    = 32;
    localparam int RF_DEPTH    = 32;
    localparam int RF_NR       = 2;
    localparam int RF_NW       = 1;
    localparam int RF_ZERO_REG = 1;
    localparam int RF_BYPASS   = 1;

endpackage : regfile_pkg

// File: rtl/regfile_clear_fsm.sv
// Zeroing sweep controller: walks every entry once after reset or a soft
// clear, then raises ready and stays in RUN until the next clear.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_idx,
    output logic          ready
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;

    // State, sweep counter and ready flag; all return to the sweep start on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic: a clear always restarts the sweep from entry 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_CLEAR: begin
                if (clear) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = RF_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RF_RUN: begin
                if (clear) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d == RF_RUN);
    end

    assign sweep_we  = (state_q == RF_CLEAR);
    assign sweep_idx = cnt_q;
    assign ready     = ready_q;

endmodule : regfile_clear_fsm

// File: rtl/regfile_multiport.sv
// Multi-port register file: NR registered read ports, NW write ports,
// optional hardwired-zero entry 0, optional write-to-read bypass, and a
// zeroing sweep after reset or soft clear that gates all port traffic.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NR       = RF_NR,
    parameter int NW       = RF_NW,
    parameter int ZERO_REG = RF_ZERO_REG,
    parameter int BYPASS   = RF_BYPASS,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clear,
    input  logic [NW-1:0]       wr_en,
    input  logic [NW*AW-1:0]    wr_idx,
    input  logic [NW*WIDTH-1:0] wr_data,
    input  logic [NR-1:0]       rd_en,
    input  logic [NR*AW-1:0]    rd_idx,
    output logic [NR*WIDTH-1:0] rd_data,
    output logic                ready
);

    // DEPTH widened by one bit so indices can be range-checked when DEPTH
    // is not a power of two.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             sweep_we;
    logic [AW-1:0]    sweep_idx;

    logic [AW-1:0]    widx  [NW];
    logic [WIDTH-1:0] wdata [NW];
    logic [NW-1:0]    port_we;

    // An index addresses real, writable storage.
    function automatic logic wr_ok(input logic [AW-1:0] idx);
        return ({1'b0, idx} < DEPTH_W) && !((ZERO_REG != 0) && (idx == '0));
    endfunction

    // An index returns stored data rather than a forced zero.
    function automatic logic rd_ok(input logic [AW-1:0] idx);
        return ({1'b0, idx} < DEPTH_W) && !((ZERO_REG != 0) && (idx == '0));
    endfunction

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .sweep_we  (sweep_we),
        .sweep_idx (sweep_idx),
        .ready     (ready)
    );

    // Unpack write ports and qualify each one; dropped writes never commit or bypass.
    always_comb begin
        port_we = '0;
        for (int q = 0; q < NW; q++) begin
            widx[q]    = wr_idx[q*AW +: AW];
            wdata[q]   = wr_data[q*WIDTH +: WIDTH];
            port_we[q] = ready && enable && wr_en[q] && wr_ok(widx[q]);
        end
    end

    // Storage: the sweep owns the array while clearing; otherwise ports
    // commit in ascending order so the highest port wins on a shared index.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_idx] <= '0;
        end else begin
            for (int q = 0; q < NW; q++) begin
                if (port_we[q]) begin
                    mem[widx[q]] <= wdata[q];
                end
            end
        end
    end

    for (genvar p = 0; p < NR; p++) begin : g_rd
        logic [AW-1:0]    ridx;
        logic [WIDTH-1:0] rnext;
        logic [WIDTH-1:0] rq;

        assign ridx = rd_idx[p*AW +: AW];

        // Read value with optional forwarding of the winning same-cycle write.
        always_comb begin
            rnext = '0;
            if (rd_ok(ridx)) begin
                rnext = mem[ridx];
                if (BYPASS != 0) begin
                    for (int q = 0; q < NW; q++) begin
                        if (port_we[q] && (widx[q] == ridx)) begin
                            rnext = wdata[q];
                        end
                    end
                end
            end
        end

        // Registered read data; holds unless a read is accepted this cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rq <= '0;
            end else if (ready && enable && rd_en[p]) begin
                rq <= rnext;
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = rq;
    end

endmodule : regfile_multiport

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport (two write ports, other parameters
// at their defaults) with a behavioural model checked on every cycle.
module tb_regfile_multiport;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic              clear = 1'b0;
    logic [NW-1:0]     wr_en = '0;
    logic [NW*AW-1:0]  wr_idx = '0;
    logic [NW*W-1:0]   wr_data = '0;
    logic [NR-1:0]     rd_en = '0;
    logic [NR*AW-1:0]  rd_idx = '0;
    logic [NR*W-1:0]   rd_data;
    logic              ready;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_on = 1'b0;

    regfile_multiport #(
        .WIDTH (W), .DEPTH (D), .NR (NR), .NW (NW), .ZERO_REG (1), .BYPASS (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .clear   (clear),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [D];
    logic [31:0] m_rd  [NR];
    logic        m_ready;
    int          m_left;

    function automatic logic [31:0] m_read(input int p);
        int idx;
        logic [31:0] v;
        idx = int'(rd_idx[p*AW +: AW]);
        if (idx == 0 || idx >= D) return 32'h0;
        v = m_mem[idx];
        for (int q = 0; q < NW; q++)
            if (wr_en[q] && int'(wr_idx[q*AW +: AW]) == idx) v = wr_data[q*W +: W];
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready <= 1'b0;
            m_left  <= D;
            for (int p = 0; p < NR; p++) m_rd[p] <= 32'h0;
        end else if (!m_ready) begin
            if (clear) m_left <= D;
            else if (m_left == 1) begin
                m_ready <= 1'b1;
                m_left  <= 0;
                for (int i = 0; i < D; i++) m_mem[i] <= 32'h0;
            end else m_left <= m_left - 1;
        end else begin
            if (enable) begin
                for (int p = 0; p < NR; p++)
                    if (rd_en[p]) m_rd[p] <= m_read(p);
                for (int q = 0; q < NW; q++)
                    if (wr_en[q] && wr_idx[q*AW +: AW] != 0) m_mem[wr_idx[q*AW +: AW]] <= wr_data[q*W +: W];
            end
            if (clear) begin
                m_ready <= 1'b0;
                m_left  <= D;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ready", {31'b0, ready}, {31'b0, m_ready});
            for (int p = 0; p < NR; p++)
                chk($sformatf("rd_data%0d", p), rd_data[p*W +: W], m_rd[p]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0;
        rd_en = '0;
        clear = 1'b0;
    endtask

    task automatic set_wr(input int q, input int idx, input logic [31:0] d);
        wr_en[q] = 1'b1;
        wr_idx[q*AW +: AW] = AW'(idx);
        wr_data[q*W +: W] = d;
    endtask

    task automatic set_rd(input int p, input int idx);
        rd_en[p] = 1'b1;
        rd_idx[p*AW +: AW] = AW'(idx);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            cyc();
            n++;
        end
        chk(name, 32'(n), 32'd32);
    endtask

    initial begin
        cyc();
        // 1: reset, sweep latency, all entries read zero
        rst = 1'b1;
        chk_on = 1'b1;
        repeat (3) cyc();
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_rd0", rd_data[0 +: W], 32'h0);
        chk("rst_rd1", rd_data[W +: W], 32'h0);
        rst = 1'b0;
        enable = 1'b1;
        wait_ready("sweep_after_reset");
        for (int i = 0; i < D; i += 2) begin
            idle(); set_rd(0, i); set_rd(1, i + 1);
            cyc();
            chk($sformatf("zero_r%0d", i), rd_data[0 +: W], 32'h0);
            chk($sformatf("zero_r%0d", i + 1), rd_data[W +: W], 32'h0);
        end

        // 2: write r5 then read it on port 1; port 0 holds (last read r30 = 0)
        idle(); set_wr(0, 5, 32'hDEADBEEF); cyc();
        idle(); set_rd(1, 5); cyc();
        chk("r5_port1", rd_data[W +: W], 32'hDEADBEEF);
        chk("port0_hold", rd_data[0 +: W], 32'h0);

        // 3: same-cycle write and read of r7 is forwarded
        idle(); set_wr(0, 7, 32'h12345678); set_rd(0, 7); cyc();
        chk("bypass_r7", rd_data[0 +: W], 32'h12345678);

        // 4: r0 is hardwired zero, including bypass
        idle(); set_wr(1, 0, 32'hFFFFFFFF); set_rd(1, 0); cyc();
        chk("r0_bypass", rd_data[W +: W], 32'h0);
        idle(); set_rd(0, 0); cyc();
        chk("r0_read", rd_data[0 +: W], 32'h0);

        // 5: both ports write r3, highest port wins (also through bypass)
        idle(); set_wr(0, 3, 32'hA); set_wr(1, 3, 32'hB); set_rd(1, 3); cyc();
        chk("prio_bypass", rd_data[W +: W], 32'h0000000B);
        idle(); set_rd(0, 3); set_rd(1, 5); cyc();
        chk("prio_r3", rd_data[0 +: W], 32'h0000000B);
        chk("r5_again", rd_data[W +: W], 32'hDEADBEEF);

        // enable low: no write to r10, rd_data holds
        enable = 1'b0;
        idle(); set_wr(0, 10, 32'h1); set_rd(0, 7); cyc();
        chk("en0_hold", rd_data[0 +: W], 32'h0000000B);
        enable = 1'b1;
        idle(); set_rd(0, 10); cyc();
        chk("en0_nowrite", rd_data[0 +: W], 32'h0);

        // 6a: soft clear from RUN; the write in the clear cycle still happens
        idle(); set_wr(0, 9, 32'h55); cyc();
        idle(); set_rd(0, 9); clear = 1'b1; set_wr(1, 11, 32'h77); cyc();
        chk("clr_read", rd_data[0 +: W], 32'h55);
        chk("clr_ready", {31'b0, ready}, 32'h0);
        idle();
        wait_ready("sweep_after_clear");
        idle(); set_rd(0, 9); set_rd(1, 11); cyc();
        chk("r9_cleared", rd_data[0 +: W], 32'h0);
        chk("r11_cleared", rd_data[W +: W], 32'h0);

        // clear during the sweep restarts it
        idle(); set_wr(0, 9, 32'h55); cyc();
        clear = 1'b1; cyc();
        idle(); repeat (10) cyc();
        clear = 1'b1; cyc();
        idle();
        wait_ready("sweep_restart");

        // 6b: same with reset mid-RUN
        idle(); set_wr(0, 9, 32'h55); cyc();
        idle(); set_rd(0, 9); cyc();
        chk("r9_written", rd_data[0 +: W], 32'h55);
        idle(); rst = 1'b1; cyc();
        chk("rst2_ready", {31'b0, ready}, 32'h0);
        chk("rst2_rd0", rd_data[0 +: W], 32'h0);
        rst = 1'b0;
        wait_ready("sweep_after_rst2");
        idle(); set_rd(1, 9); cyc();
        chk("r9_after_rst", rd_data[W +: W], 32'h0);

        idle(); cyc();
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_regfile_multiport
